// File: rtl/bcd_pkg.sv
// Shared BCD constants and helpers for the score counter and the display decoder.
package bcd_pkg;

  localparam int         DIGIT_W  = 4;
  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  // Steps above 9 cannot be shown in one digit, so they saturate at 9.
  function automatic logic [DIGIT_W-1:0] clampStep(input logic [DIGIT_W-1:0] raw);
    return (raw > BCD_MAX) ? BCD_MAX : raw;
  endfunction

endpackage

// File: rtl/bcd_score_counter_if.sv
// Control and result bundle between the hit-judgement logic and the score counter.
interface bcd_score_counter_if #(
  parameter int DIGITS = 4
);

  logic                  CLEAR;
  logic                  EN;
  logic [3:0]            INC;
  logic                  DEC;
  logic [4*DIGITS-1:0]   OUT;
  logic                  NEXT;
  logic                  BORROW;
  logic                  ZERO;
  logic                  MAXED;

  modport master (
    output CLEAR, EN, INC, DEC,
    input  OUT, NEXT, BORROW, ZERO, MAXED
  );

  modport slave (
    input  CLEAR, EN, INC, DEC,
    output OUT, NEXT, BORROW, ZERO, MAXED
  );

endinterface

// File: rtl/bcd_digit_cell.sv
// One BCD digit: add-with-carry, or subtract-with-borrow when sub is set.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] d,
  input  logic [DIGIT_W-1:0] addend,
  input  logic               cin,
  input  logic               sub,
  output logic [DIGIT_W-1:0] q,
  output logic               cout
);

  logic [DIGIT_W:0] sum;

  // In subtract mode cin is the borrow-in and addend is ignored.
  always_comb begin
    sum  = {1'b0, d} + {1'b0, addend} + {{DIGIT_W{1'b0}}, cin};
    q    = d;
    cout = 1'b0;
    if (sub) begin
      if (cin) begin
        if (d == BCD_ZERO) begin
          q    = BCD_MAX;
          cout = 1'b1;
        end else begin
          q = d - 4'd1;
        end
      end
    end else if (sum > {1'b0, BCD_MAX}) begin
      q    = DIGIT_W'(sum - 5'd10);
      cout = 1'b1;
    end else begin
      q = sum[DIGIT_W-1:0];
    end
  end

endmodule

// File: rtl/bcd_score_counter.sv
// Multi-digit BCD score counter with step 0..9, decrement, wrap/saturate and carry/borrow pulses.
module bcd_score_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter bit SATURATE = 1'b1
) (
  input  logic                CLOCK,
  input  logic                RESET,
  bcd_score_counter_if.slave  bus
);

  localparam int W = DIGIT_W * DIGITS;
  localparam logic [W-1:0] ALL_NINES = {DIGITS{BCD_MAX}};

  logic [W-1:0]       count_q, count_d;
  logic               next_q, next_d;
  logic               borrow_q, borrow_d;
  logic               zero_q, maxed_q;
  logic [W-1:0]       cellSum;
  logic [DIGITS:0]    carryChain;
  logic [DIGIT_W-1:0] incClamped;
  logic [DIGIT_W-1:0] stepMag;
  logic               doAdd, doSub;

  // Net step is min(INC,9) - DEC: positive adds, exactly -1 subtracts, zero holds.
  assign incClamped = clampStep(bus.INC);
  assign doAdd      = bus.EN && (incClamped > {3'b000, bus.DEC});
  assign doSub      = bus.EN && (incClamped == BCD_ZERO) && bus.DEC;
  assign stepMag    = incClamped - {3'b000, bus.DEC};

  assign carryChain[0] = doSub;

  for (genvar g = 0; g < DIGITS; g++) begin : gen_digit
    bcd_digit_cell u_cell (
      .d      (count_q[g*DIGIT_W +: DIGIT_W]),
      .addend ((g == 0) ? stepMag : BCD_ZERO),
      .cin    (carryChain[g]),
      .sub    (doSub),
      .q      (cellSum[g*DIGIT_W +: DIGIT_W]),
      .cout   (carryChain[g+1])
    );
  end

  always_comb begin
    count_d  = count_q;
    next_d   = 1'b0;
    borrow_d = 1'b0;
    if (bus.CLEAR) begin
      count_d = '0;
    end else if (doAdd) begin
      count_d = cellSum;
      if (carryChain[DIGITS]) begin
        next_d = 1'b1;
        if (SATURATE) count_d = ALL_NINES;
      end
    end else if (doSub) begin
      count_d = cellSum;
      if (carryChain[DIGITS]) begin
        borrow_d = 1'b1;
        if (SATURATE) count_d = '0;
      end
    end
  end

  // Flags are computed from the next value so they line up with OUT.
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      count_q  <= '0;
      next_q   <= 1'b0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b1;
      maxed_q  <= 1'b0;
    end else begin
      count_q  <= count_d;
      next_q   <= next_d;
      borrow_q <= borrow_d;
      zero_q   <= (count_d == '0);
      maxed_q  <= (count_d == ALL_NINES);
    end
  end

  assign bus.OUT    = count_q;
  assign bus.NEXT   = next_q;
  assign bus.BORROW = borrow_q;
  assign bus.ZERO   = zero_q;
  assign bus.MAXED  = maxed_q;

endmodule

// File: doc/bcd_score_counter.md
Name: bcd_score_counter

Overview:
- Parametrised multi-digit BCD up/down counter for game score and combo tracking; successor to the single-digit decimal counter.
- Adds a variable step of 0-9 per cycle, supports decrement, and offers wrap or saturate mode.
- Provides carry/borrow pulses for chaining, plus zero/max status flags.
- Sits between hit-judgement logic and the 7-segment display drivers; each 4-bit OUT nibble feeds one display.

Parameters:
- DIGITS, 4: number of BCD digits, 1..8; OUT width is 4*DIGITS.
- SATURATE, 1: 1 = clamp at all-9s / all-0s; 0 = modulo 10^DIGITS wrap.

Ports:
- CLOCK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-low reset.
- CLEAR  in  1  synchronous clear to zero; no pulses generated.
- EN  in  1  count enable; INC and DEC are ignored when low.
- INC  in  4  binary step 0..9 added to the counter; values 10..15 are clamped to 9.
- DEC  in  1  subtract 1.
- OUT  out  4*DIGITS  BCD value; digit 0 is OUT[3:0] (least significant).
- NEXT  out  1  one-cycle pulse on overflow past all-9s.
- BORROW  out  1  one-cycle pulse on underflow below zero.
- ZERO  out  1  level; high when OUT == 0.
- MAXED  out  1  level; high when every digit == 9.

Behaviour:
- Reset: RESET low at a clock edge sets OUT=0, NEXT=0, BORROW=0, ZERO=1, MAXED=0. RESET has priority over all other inputs.
- Priority order: RESET, then CLEAR, then EN-qualified update. CLEAR forces OUT=0 and NEXT=BORROW=0, regardless of INC/DEC.
- Net step s = min(INC,9) - DEC, range -1..+9:
  - s = 0: hold, no pulses.
  - s > 0: BCD add.
  - s = -1: BCD subtract 1.
- Simultaneous INC and DEC combine into s: INC=1 with DEC=1 is a hold; INC=0 with DEC=1 subtracts 1.
- Latency: OUT, NEXT, BORROW, ZERO and MAXED are all registered and reflect the inputs sampled on the previous edge. No combinational input-to-output path exists.
- Add path:
  - Digit 0 receives s; each higher digit receives the carry from the digit below.
  - Per digit: t = d + addend + cin; if t > 9 then d' = t - 10 and cout = 1, else d' = t and cout = 0.
- Subtract path: borrow chain starting at digit 0; a digit equal to 0 with borrow-in becomes 9 and borrows out.
- Overflow (carry out of the top digit):
  - SATURATE=1: OUT becomes all-9s, NEXT=1 for one cycle.
  - SATURATE=0: OUT keeps the wrapped value, NEXT=1 for one cycle.
- Underflow (borrow out of the top digit):
  - SATURATE=1: OUT stays 0, BORROW=1 for one cycle.
  - SATURATE=0: OUT becomes all-9s, BORROW=1 for one cycle.
- NEXT and BORROW are never high in the same cycle. Both are low in any cycle whose preceding edge had no overflow/underflow.
- Holding at all-9s with further adds in saturate mode produces a NEXT pulse on every such cycle; this signals lost points.
- Internal digit registers are always valid BCD (0..9). No state can hold A..F.
- RESET asserted mid-sequence discards any pending step; the next edge after RESET returns high samples inputs normally.

Decomposition:
- Shared package (bcd_pkg): BCD_MAX = 4'd9, BCD_ZERO = 4'd0, and a digit-width constant of 4. Shared with the display decoder.
- Sub-module bcd_digit_cell, combinational:
  - Inputs: d[3:0], addend[3:0], cin, sub.
  - Outputs: q[3:0], cout.
  - Performs the add-with-carry or subtract-with-borrow rule above.
- The top module instantiates DIGITS cells in a generate loop and adds the step/saturate logic, registers and flags.

Test Plan (DIGITS=4 unless noted):
- RESET low for 2 edges with EN=1, INC=5 -> OUT=0000, ZERO=1, NEXT=BORROW=0. After release, one edge with INC=5 -> OUT=0005.
- OUT=0008, INC=4 for 1 cycle -> OUT=0012. OUT=0999, INC=1 -> OUT=1000 with no NEXT. INC=15 from 0000 -> OUT=0009 (clamped).
- SATURATE=1: OUT=9995, INC=7 -> OUT=9999, NEXT high for exactly 1 cycle, MAXED=1. Repeated INC=1 -> OUT stays 9999 and NEXT pulses on each cycle.
- SATURATE=0: OUT=9995, INC=7 -> OUT=0002, NEXT 1 cycle. Then OUT=0000, DEC=1 -> OUT=9999, BORROW 1 cycle.
- SATURATE=1: OUT=0000, DEC=1 -> OUT=0000, BORROW=1. OUT=1000, DEC=1 -> OUT=0999. INC=3 with DEC=1 from 0010 -> OUT=0012. INC=1 with DEC=1 -> hold.
- OUT=0450, EN=0, INC=9 -> hold at 0450. CLEAR=1 together with INC=9 -> OUT=0000, no pulses. DIGITS=1 run: 9 + 1 -> NEXT pulse.
